// File: rtl/in_capture.sv
// -----------------------------------------------------------------------------
// in_capture
// Input front-end between the board buttons/switches and the CPU input port.
// Buttons and switches are brought into clk with two-flop synchronisers; each
// button is debounced independently. A debounced press of btn[0] captures the
// low SW_WIDTH switch bits into data_out, and btn[1] flushes the holding
// register. btn[2] is debounced and exposed only.
//
// Ports
//   clk        board clock
//   rst        synchronous reset, active-high
//   btn[2:0]   raw asynchronous push-buttons (polarity set by BTN_ACTIVE_LOW)
//   sw[8:0]    raw asynchronous slide switches
//   rd         one-cycle CPU read strobe, consumes the current word
//   data_out   captured word, zero-extended switch field
//   valid      data_out holds an unread capture
//   overrun    sticky, a capture overwrote an unread word
//   btn_level  debounced pressed level (1 = pressed)
//   btn_pulse  one-cycle pulse on each debounced press
// -----------------------------------------------------------------------------
module in_capture #(
    parameter int DATA_WIDTH      = 16,
    parameter int SW_WIDTH        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            btn,
    input  logic [8:0]            sw,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  overrun,
    output logic [2:0]            btn_level,
    output logic [2:0]            btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; also the synchroniser reset value so
    // that leaving reset never looks like a press.
    localparam logic [2:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [2:0]            btn_s1_q, btn_s2_q;
    logic [8:0]            sw_s1_q, sw_s2_q;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            level_q, level_d;
    logic [2:0]            pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [2:0]            pressed;

    // Upper switch bits are synchronised but intentionally not captured.
    logic unused_sw;
    assign unused_sw = ^sw_s2_q;

    assign pressed = btn_s2_q ^ BTN_IDLE;

    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 3'b000;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // Debounce: any sample equal to the accepted level restarts the count,
        // so only an unbroken run of DEBOUNCE_CYCLES differing samples wins.
        for (int i = 0; i < 3; i++) begin
            if (pressed[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                cnt_d[i]   = '0;
                level_d[i] = pressed[i];
                pulse_d[i] = pressed[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Capture beats flush beats read. A simultaneous flush is applied
        // before the capture, so it both clears overrun and suppresses a new one.
        if (pulse_q[0]) begin
            data_d  = DATA_WIDTH'(sw_s2_q[SW_WIDTH-1:0]);
            valid_d = 1'b1;
            if (pulse_q[1]) begin
                overrun_d = 1'b0;
            end else if (valid_q && !rd) begin
                overrun_d = 1'b1;
            end
        end else if (pulse_q[1]) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else if (rd && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q  <= BTN_IDLE;
            btn_s2_q  <= BTN_IDLE;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            btn_s1_q  <= btn;
            btn_s2_q  <= btn_s1_q;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_in_capture.sv
module tb_in_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  btn;
    logic [8:0]  sw;
    logic        rd;
    logic [15:0] data_out;
    logic        valid;
    logic        overrun;
    logic [2:0]  btn_level;
    logic [2:0]  btn_pulse;

    int n_cmp = 0;
    int n_err = 0;

    in_capture #(
        .DATA_WIDTH(16),
        .SW_WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .sw(sw),
        .rd(rd),
        .data_out(data_out),
        .valid(valid),
        .overrun(overrun),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btn = 3'b111; sw = 9'h000; rd = 1'b0;

        // 1. reset then idle
        tick(2);
        rst = 1'b0;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_pulse", 32'(btn_pulse), 32'h0);

        // 2. clean press: level rises on edge 6, capture on edge 7
        sw = 9'h00A; btn = 3'b110;
        tick(5);
        chk("press_level_e5", 32'(btn_level), 32'h0);
        tick(1);
        chk("press_level_e6", 32'(btn_level), 32'h1);
        chk("press_pulse_e6", 32'(btn_pulse), 32'h1);
        chk("press_valid_e6", 32'(valid), 32'h0);
        tick(1);
        chk("press_pulse_e7", 32'(btn_pulse), 32'h0);
        chk("press_data_e7", 32'(data_out), 32'h000A);
        chk("press_valid_e7", 32'(valid), 32'h1);
        tick(3);
        chk("hold_pulse", 32'(btn_pulse), 32'h0);

        // 4. read handshake
        rd = 1'b1; tick(1); rd = 1'b0;
        chk("rd_valid", 32'(valid), 32'h0);
        chk("rd_data", 32'(data_out), 32'h000A);
        rd = 1'b1; tick(1); rd = 1'b0;
        chk("rd2_valid", 32'(valid), 32'h0);
        chk("rd2_data", 32'(data_out), 32'h000A);
        chk("rd2_overrun", 32'(overrun), 32'h0);

        // release: no pulse, level falls
        btn = 3'b111;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("release_pulse", 32'(btn_pulse), 32'h0);
        end
        chk("release_level", 32'(btn_level), 32'h0);

        // 3. bounce: 2-cycle toggles never reach the 4-sample run
        for (int k = 0; k < 20; k++) begin
            btn[0] = k[1];
            tick(1);
            chk("bounce_level", 32'(btn_level), 32'h0);
            chk("bounce_pulse", 32'(btn_pulse), 32'h0);
        end
        btn = 3'b111;
        tick(6);
        chk("bounce_level_end", 32'(btn_level), 32'h0);
        chk("bounce_valid", 32'(valid), 32'h0);

        // 5. overrun
        sw = 9'h003; btn = 3'b110; tick(8);
        chk("ovr_first_data", 32'(data_out), 32'h0003);
        chk("ovr_first_valid", 32'(valid), 32'h1);
        chk("ovr_first_ovr", 32'(overrun), 32'h0);
        btn = 3'b111; tick(8);
        sw = 9'h005; btn = 3'b110; tick(8);
        chk("ovr_data", 32'(data_out), 32'h0005);
        chk("ovr_valid", 32'(valid), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'h1);
        btn = 3'b111; tick(8);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        btn = 3'b101; tick(6);
        chk("flush_level", 32'(btn_level), 32'h2);
        chk("flush_pulse", 32'(btn_pulse), 32'h2);
        tick(1);
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_ovr", 32'(overrun), 32'h0);
        chk("flush_data", 32'(data_out), 32'h0005);
        btn = 3'b111; tick(8);

        // 6a. capture + rd in the same cycle, upper switch bits ignored
        sw = 9'h007; btn = 3'b110; tick(8);
        btn = 3'b111; tick(8);
        chk("sim_pre_valid", 32'(valid), 32'h1);
        chk("sim_pre_data", 32'(data_out), 32'h0007);
        sw = 9'h1F9; btn = 3'b110; tick(6);
        chk("sim_pulse", 32'(btn_pulse), 32'h1);
        rd = 1'b1; tick(1); rd = 1'b0;
        chk("sim_valid", 32'(valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);
        chk("sim_data", 32'(data_out), 32'h0009);
        btn = 3'b111; tick(8);

        // 6b. reset during a half-counted press loses it
        sw = 9'h002; btn = 3'b110; tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_data", 32'(data_out), 32'h0);
        chk("midrst_level", 32'(btn_level), 32'h0);
        tick(5);
        chk("midrst_level_e5", 32'(btn_level), 32'h0);
        tick(1);
        chk("midrst_level_e6", 32'(btn_level), 32'h1);
        chk("midrst_pulse_e6", 32'(btn_pulse), 32'h1);
        tick(1);
        chk("midrst_data_e7", 32'(data_out), 32'h0002);
        chk("midrst_valid_e7", 32'(valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
